// File: rtl/stroke_walker.sv
// Stroke sequencer: fetches segments from a combinational stroke ROM and
// rasterises each with integer Bresenham into a valid/ready point stream.
module stroke_walker #(
    parameter int COORD_W = 8,
    parameter int IDX_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W-1:0]   seg_count,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   idx,
    output logic               rom_en,
    input  logic [COORD_W-1:0] rom_start_x,
    input  logic [COORD_W-1:0] rom_start_y,
    input  logic [COORD_W-1:0] rom_end_x,
    input  logic [COORD_W-1:0] rom_end_y,
    input  logic               rom_pen_down,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    output logic               pt_pen
);
    localparam int DW = COORD_W + 2;
    localparam logic [IDX_W-1:0]   IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [COORD_W-1:0] C_ONE   = {{(COORD_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_NEXT, S_DONE} state_t;
    state_t r_state, w_nstate;

    logic [IDX_W-1:0]     r_cnt, r_idx;
    logic                 r_rom_en, r_pen, r_sxp, r_syp;
    logic [COORD_W-1:0]   r_cx, r_cy, r_ex, r_ey;
    logic signed [DW-1:0] r_dx, r_dy, r_err;

    logic [COORD_W-1:0]   w_adx, w_ady;
    logic signed [DW:0]   w_e2, w_dxe, w_dye;
    logic signed [DW-1:0] w_err_n;
    logic                 w_hs, w_at_end, w_last, w_xs, w_ys;

    assign w_adx = (rom_end_x >= rom_start_x) ? rom_end_x - rom_start_x : rom_start_x - rom_end_x;
    assign w_ady = (rom_end_y >= rom_start_y) ? rom_end_y - rom_start_y : rom_start_y - rom_end_y;

    assign w_hs     = (r_state == S_STEP) && pt_ready;
    assign w_at_end = (r_cx == r_ex) && (r_cy == r_ey);
    assign w_last   = (r_idx == r_cnt - IDX_ONE);

    // e2 needs one extra bit over err: err can reach roughly 1.5x the span
    assign w_e2  = $signed({r_err, 1'b0});
    assign w_dxe = $signed({r_dx[DW-1], r_dx});
    assign w_dye = $signed({r_dy[DW-1], r_dy});
    assign w_xs  = (w_e2 >= w_dye);
    assign w_ys  = (w_e2 <= w_dxe);

    always_comb begin
        w_err_n = r_err;
        if (w_xs) w_err_n = w_err_n + r_dy;
        if (w_ys) w_err_n = w_err_n + r_dx;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE: if (start) w_nstate = (seg_count == '0) ? S_DONE : S_LOAD;
            S_LOAD: w_nstate = S_STEP;
            S_STEP: if (w_hs && w_at_end) w_nstate = S_NEXT;
            S_NEXT: w_nstate = w_last ? S_DONE : S_LOAD;
            S_DONE: w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nstate;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0; r_idx <= '0; r_rom_en <= 1'b0;
            r_cx  <= '0; r_cy  <= '0; r_ex <= '0; r_ey <= '0;
            r_pen <= 1'b0; r_sxp <= 1'b0; r_syp <= 1'b0;
            r_dx  <= '0; r_dy  <= '0; r_err <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_cnt <= seg_count;
                    if (seg_count != '0) begin
                        r_idx    <= '0;
                        r_rom_en <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_cx  <= rom_start_x;
                    r_cy  <= rom_start_y;
                    r_ex  <= rom_end_x;
                    r_ey  <= rom_end_y;
                    r_pen <= rom_pen_down;
                    r_sxp <= rom_start_x < rom_end_x;
                    r_syp <= rom_start_y < rom_end_y;
                    r_dx  <= $signed({2'b00, w_adx});
                    r_dy  <= -$signed({2'b00, w_ady});
                    r_err <= $signed({2'b00, w_adx}) - $signed({2'b00, w_ady});
                end
                S_STEP: if (w_hs && !w_at_end) begin
                    r_err <= w_err_n;
                    if (w_xs) r_cx <= r_sxp ? r_cx + C_ONE : r_cx - C_ONE;
                    if (w_ys) r_cy <= r_syp ? r_cy + C_ONE : r_cy - C_ONE;
                end
                S_NEXT: if (!w_last) r_idx <= r_idx + IDX_ONE;
                S_DONE: begin
                    r_rom_en <= 1'b0;
                    r_idx    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign pt_valid = (r_state == S_STEP);
    assign idx      = r_idx;
    assign rom_en   = r_rom_en;
    assign pt_x     = r_cx;
    assign pt_y     = r_cy;
    assign pt_pen   = r_pen;
endmodule

// File: doc/stroke_walker.md
Name: stroke_walker

Overview:
- Sequencer that sits between a digit stroke ROM and the pen/pixel back-end.
- Drives the ROM's segment index and enable, and latches each segment's start point, end point and pen state.
- Rasterises each segment into unit steps using integer Bresenham.
- Streams the points downstream over a valid/ready handshake, one point per cycle when not stalled.

Parameters:
- COORD_W, 8, width of every x/y coordinate.
- IDX_W, 5, width of the segment index and of seg_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin walking a stroke list; sampled only in IDLE.
- seg_count  input  IDX_W  number of segments to walk; sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the walk completes.
- idx  output  IDX_W  segment index to the ROM; registered.
- rom_en  output  1  enable to the ROM; registered.
- rom_start_x, rom_start_y  input  COORD_W each  segment start point from the ROM.
- rom_end_x, rom_end_y  input  COORD_W each  segment end point from the ROM.
- rom_pen_down  input  1  segment pen state from the ROM.
- pt_valid  output  1  point available.
- pt_ready  input  1  downstream accepts the point.
- pt_x, pt_y  output  COORD_W each  current point.
- pt_pen  output  1  pen state of the current point.

Behaviour:
- Reset (async, immediate): state IDLE; idx=0, rom_en=0, busy=0, done=0, pt_valid=0, pt_x=0, pt_y=0, pt_pen=0; all internal registers cleared.
- The ROM is combinational; its outputs are sampled in the cycle after idx/rom_en change.
- IDLE: on start=1, latch seg_count into cnt.
  - cnt==0: go to DONE.
  - Otherwise: idx<=0, rom_en<=1, go to LOAD.
- LOAD (1 cycle):
  - Latch sx, sy, ex, ey, pen.
  - cur_x<=sx, cur_y<=sy.
  - dx = |ex-sx|, dy = -|ey-sy|, err = dx+dy. Use signed width COORD_W+2 so nothing overflows.
  - step_x = +1 if sx<ex else -1; step_y = +1 if sy<ey else -1.
  - Go to STEP.
- STEP:
  - pt_valid=1, pt_x=cur_x, pt_y=cur_y, pt_pen=pen.
  - Outputs hold stable while pt_valid && !pt_ready.
  - On handshake with cur==end: go to NEXT.
  - On handshake otherwise, apply the Bresenham update and stay in STEP:
    - e2 = 2*err.
    - If e2>=dy: err+=dy, cur_x+=step_x.
    - If e2<=dx: err+=dx, cur_y+=step_y.
    - Both updates apply in the same cycle when both hold.
  - Both endpoints are emitted. A zero-length segment emits exactly one point.
  - Shared vertices between consecutive segments are emitted twice; the back-end tolerates this.
- NEXT (pt_valid=0):
  - idx==cnt-1: go to DONE.
  - Otherwise: idx<=idx+1, go to LOAD.
- DONE:
  - done=1 for this cycle only; rom_en<=0, idx<=0.
  - Go to IDLE. busy stays high during DONE.
- start is ignored while busy.
- seg_count changes are ignored after it is latched.
- pt_ready has no effect outside STEP.
- Reset mid-walk aborts with no further points and no done pulse.
- Coordinates never wrap: Bresenham stays within the [min, max] of the two endpoints.
- Throughput with pt_ready held high, for a segment of N points: 1 LOAD + N STEP + 1 NEXT cycles.

Test Plan:
- Bench ROM model of three segments with seg_count=3, pt_ready=1 throughout:
  - seg0: (0,0)->(60,80), pen 0.
  - seg1: (60,80)->(180,80), pen 1.
  - seg2: (180,80)->(0,0), pen 0.
  - Required: 81, 121 and 181 points respectively (383 total). First point (0,0) pen 0; (60,80) appears last in seg0 and first in seg1; seg1 points all pen 1 with y=80 and x incrementing by 1; last point (0,0).
  - done pulses exactly once, in the 390th cycle after start is sampled.
  - Every consecutive point pair differs by at most 1 in x and in y.
- Same stimulus with pt_ready toggled pseudo-randomly:
  - Identical point sequence.
  - pt_x, pt_y and pt_pen hold stable while stalled.
  - No point is lost or duplicated.
- Zero-length segment (5,5)->(5,5), seg_count=1:
  - Exactly one point (5,5).
  - done follows on the 4th cycle after start.
- seg_count=0:
  - No pt_valid.
  - rom_en stays 0.
  - done pulses one cycle after start.
- start pulsed again mid-walk:
  - Ignored; the sequence is unchanged.
- rst asserted during seg1 STEP:
  - All outputs 0 immediately.
  - No done pulse.
  - A fresh start then replays from idx 0.
